cc_req_decoder: RTL and testbench

//  Registered, parametrised front-end decoder for the cache controller read path. Accepts AR

---
 rtl/cc_req_decoder.sv | 99 +++++++++
 tb/tb_cc_req_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cc_req_decoder.sv
// Read-path front end: two-entry skid FIFO for AR requests, splits the head address into
// tag/index/offset and issues it when no downstream FIFO is almost full.
module cc_req_decoder #(
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 6,
   parameter int INDEX_W  = 9,
   parameter int NUM_FIFO = 4,
   parameter int SEQ_W    = 4,
   parameter int STALL_W  = 8,
   localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   inct_araddr_i,
   input  logic                inct_arvalid_i,
   output logic                inct_arready_o,
   input  logic [NUM_FIFO-1:0] fifo_afull_i,
   output logic                req_valid_o,
   output logic [TAG_W-1:0]    tag_o,
   output logic [INDEX_W-1:0]  index_o,
   output logic [OFFSET_W-1:0] offset_o,
   output logic [SEQ_W-1:0]    seq_o,
   output logic                hs_pulse_o,
   output logic [STALL_W-1:0]  stall_cnt_o
);

   generate
      if (TAG_W < 1) begin : g_bad_tag_w
         $error("cc_req_decoder: ADDR_W must exceed INDEX_W + OFFSET_W");
      end
   endgenerate

   logic [1:0]         r_cnt;
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [SEQ_W-1:0]   r_seq_ctr;
   logic [STALL_W-1:0] r_stall_cnt;
   logic [ADDR_W-1:0]  r_addr_mem [2];
   logic [SEQ_W-1:0]   r_seq_mem  [2];

   logic              w_push;
   logic              w_pop;
   logic              w_issue_ok;
   logic [ADDR_W-1:0] w_head_addr;

   // Ready must never look at the afull flags, only at local occupancy.
   assign inct_arready_o = rst_n & (r_cnt != 2'd2);
   assign w_push         = inct_arvalid_i & inct_arready_o;
   assign w_issue_ok     = ~|fifo_afull_i;
   assign req_valid_o    = rst_n & (r_cnt != 2'd0);
   assign hs_pulse_o     = req_valid_o & w_issue_ok;
   assign w_pop          = hs_pulse_o;

   assign w_head_addr = r_addr_mem[r_rd_ptr];
   assign tag_o       = w_head_addr[ADDR_W-1 -: TAG_W];
   assign index_o     = w_head_addr[OFFSET_W +: INDEX_W];
   assign offset_o    = w_head_addr[OFFSET_W-1:0];
   assign seq_o       = r_seq_mem[r_rd_ptr];
   assign stall_cnt_o = r_stall_cnt;

   // Entry storage is never reset; its contents are invisible while the FIFO is empty.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (w_push && (r_wr_ptr == 1'(gi))) begin
               r_addr_mem[gi] <= inct_araddr_i;
               r_seq_mem[gi]  <= r_seq_ctr;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt       <= 2'd0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_seq_ctr   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr  <= ~r_wr_ptr;
            r_seq_ctr <= r_seq_ctr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 2'd1;
         end else if (w_pop && !w_push) begin
            r_cnt <= r_cnt - 2'd1;
         end
         if (req_valid_o && !w_issue_ok && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cc_req_decoder.sv
// Directed bench for cc_req_decoder with default parameters (TAG_W = 17).
module tb_cc_req_decoder;

   logic        clk;
   logic        rst_n;
   logic [31:0] inct_araddr_i;
   logic        inct_arvalid_i;
   logic        inct_arready_o;
   logic [3:0]  fifo_afull_i;
   logic        req_valid_o;
   logic [16:0] tag_o;
   logic [8:0]  index_o;
   logic [5:0]  offset_o;
   logic [3:0]  seq_o;
   logic        hs_pulse_o;
   logic [7:0]  stall_cnt_o;

   int errors = 0;
   int checks = 0;

   cc_req_decoder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .inct_araddr_i  (inct_araddr_i),
      .inct_arvalid_i (inct_arvalid_i),
      .inct_arready_o (inct_arready_o),
      .fifo_afull_i   (fifo_afull_i),
      .req_valid_o    (req_valid_o),
      .tag_o          (tag_o),
      .index_o        (index_o),
      .offset_o       (offset_o),
      .seq_o          (seq_o),
      .hs_pulse_o     (hs_pulse_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      inct_arvalid_i = 1'b0;
      fifo_afull_i   = 4'd0;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n          = 1'b0;
      inct_araddr_i  = 32'd0;
      inct_arvalid_i = 1'b0;
      fifo_afull_i   = 4'd0;
      tick();
      tick();
      // Reset state
      chk("rst_arready", 32'(inct_arready_o), 32'd0);
      chk("rst_valid",   32'(req_valid_o),    32'd0);
      chk("rst_hs",      32'(hs_pulse_o),     32'd0);
      chk("rst_stall",   32'(stall_cnt_o),    32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_arready", 32'(inct_arready_o), 32'd1);

      // 1: single request, field split of 0x1234_5678
      inct_araddr_i  = 32'h1234_5678;
      inct_arvalid_i = 1'b1;
      #1;
      chk("t1_no_bypass_valid", 32'(req_valid_o), 32'd0);
      chk("t1_no_bypass_hs",    32'(hs_pulse_o),  32'd0);
      tick();
      inct_arvalid_i = 1'b0;
      #1;
      chk("t1_hs",      32'(hs_pulse_o),     32'd1);
      chk("t1_tag",     32'(tag_o),          32'h2468);
      chk("t1_index",   32'(index_o),        32'h159);
      chk("t1_offset",  32'(offset_o),       32'h38);
      chk("t1_seq",     32'(seq_o),          32'd0);
      chk("t1_arready", 32'(inct_arready_o), 32'd1);
      $display("t1 issued tag=0x%0h index=0x%0h offset=0x%0h seq=%0d", tag_o, index_o, offset_o, seq_o);
      tick();
      chk("t1_empty", 32'(req_valid_o), 32'd0);

      // 2/4: 20 back-to-back requests, push+pop at cnt==1 every cycle
      do_reset();
      for (int k = 0; k <= 20; k++) begin
         inct_arvalid_i = (k < 20);
         inct_araddr_i  = 32'hA000_0000 | (32'(k) << 6) | 32'(k);
         #1;
         chk("t2_arready", 32'(inct_arready_o), 32'd1);
         if (k >= 1) begin
            chk("t2_hs",     32'(hs_pulse_o), 32'd1);
            chk("t2_index",  32'(index_o),    32'(k - 1));
            chk("t2_offset", 32'(offset_o),   32'(k - 1));
            chk("t2_seq",    32'(seq_o),      32'((k - 1) % 16));
            $display("t2 issue %0d seq=%0d index=%0d", k - 1, seq_o, index_o);
         end
         tick();
      end
      inct_arvalid_i = 1'b0;
      #1;
      chk("t2_drained", 32'(req_valid_o), 32'd0);

      // 3: afull[2] held, three requests offered
      do_reset();
      fifo_afull_i   = 4'b0100;
      inct_araddr_i  = 32'h0000_0040;
      inct_arvalid_i = 1'b1;
      tick();
      inct_araddr_i = 32'h0000_0081;
      #1;
      chk("t3_arready_1", 32'(inct_arready_o), 32'd1);
      chk("t3_valid_1",   32'(req_valid_o),    32'd1);
      chk("t3_hs_1",      32'(hs_pulse_o),     32'd0);
      chk("t3_stall_0",   32'(stall_cnt_o),    32'd0);
      tick();
      inct_araddr_i = 32'h0000_00C2;
      #1;
      chk("t3_arready_full", 32'(inct_arready_o), 32'd0);
      chk("t3_hs_2",         32'(hs_pulse_o),     32'd0);
      chk("t3_stall_1",      32'(stall_cnt_o),    32'd1);
      chk("t3_head_seq",     32'(seq_o),          32'd0);
      tick();
      tick();
      chk("t3_stall_3",   32'(stall_cnt_o),    32'd3);
      chk("t3_still_full", 32'(inct_arready_o), 32'd0);
      fifo_afull_i = 4'b0000;
      #1;
      chk("t3_hs_seq0",      32'(hs_pulse_o),     32'd1);
      chk("t3_seq0",         32'(seq_o),          32'd0);
      chk("t3_index0",       32'(index_o),        32'd1);
      chk("t3_ready_lowpop", 32'(inct_arready_o), 32'd0);
      tick();
      chk("t3_ready_back", 32'(inct_arready_o), 32'd1);
      chk("t3_hs_seq1",    32'(hs_pulse_o),     32'd1);
      chk("t3_seq1",       32'(seq_o),          32'd1);
      chk("t3_offset1",    32'(offset_o),       32'd1);
      chk("t3_stall_kept", 32'(stall_cnt_o),    32'd3);
      tick();
      inct_arvalid_i = 1'b0;
      #1;
      chk("t3_hs_seq2",  32'(hs_pulse_o), 32'd1);
      chk("t3_seq2",     32'(seq_o),      32'd2);
      chk("t3_index2",   32'(index_o),    32'd3);
      chk("t3_offset2",  32'(offset_o),   32'd2);
      tick();
      chk("t3_empty", 32'(req_valid_o), 32'd0);
      chk("t3_stall_final", 32'(stall_cnt_o), 32'd3);

      // 5: stall counter saturation
      do_reset();
      fifo_afull_i   = 4'b0001;
      inct_araddr_i  = 32'h0000_1000;
      inct_arvalid_i = 1'b1;
      tick();
      inct_arvalid_i = 1'b0;
      for (int i = 0; i < 254; i++) tick();
      chk("t5_stall_254", 32'(stall_cnt_o), 32'd254);
      tick();
      chk("t5_stall_255", 32'(stall_cnt_o), 32'd255);
      for (int i = 0; i < 45; i++) tick();
      chk("t5_stall_sat", 32'(stall_cnt_o), 32'd255);
      chk("t5_held_valid", 32'(req_valid_o), 32'd1);
      chk("t5_held_index", 32'(index_o),     32'h40);

      // 6: reset with two entries buffered
      inct_araddr_i  = 32'h0000_2000;
      inct_arvalid_i = 1'b1;
      tick();
      inct_arvalid_i = 1'b0;
      #1;
      chk("t6_full", 32'(inct_arready_o), 32'd0);
      rst_n        = 1'b0;
      fifo_afull_i = 4'b0000;
      #1;
      chk("t6_rst_arready", 32'(inct_arready_o), 32'd0);
      chk("t6_rst_valid",   32'(req_valid_o),    32'd0);
      chk("t6_rst_hs",      32'(hs_pulse_o),     32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("t6_after_valid",   32'(req_valid_o),    32'd0);
      chk("t6_after_stall",   32'(stall_cnt_o),    32'd0);
      chk("t6_after_arready", 32'(inct_arready_o), 32'd1);
      inct_araddr_i  = 32'h0000_3004;
      inct_arvalid_i = 1'b1;
      tick();
      inct_arvalid_i = 1'b0;
      #1;
      chk("t6_seq_restart", 32'(seq_o),      32'd0);
      chk("t6_hs",          32'(hs_pulse_o), 32'd1);
      chk("t6_offset",      32'(offset_o),   32'd4);
      tick();
      chk("t6_empty", 32'(req_valid_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
